// File: rtl/grid_renderer.sv
// Read-only grid scanner: fetches each cell type from the level RAM and paints
// it as a CELL_PX x CELL_PX block of VGA pixel writes, row-major.
module grid_renderer #(
    parameter int GRID_W  = 40,
    parameter int GRID_H  = 30,
    parameter int CELL_PX = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    output logic       done,
    output logic       busy,
    output logic [5:0] grid_x,
    output logic [4:0] grid_y,
    input  logic [2:0] grid_out,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] colour,
    output logic       plot
);

    localparam int LOG2 = $clog2(CELL_PX);
    localparam int DW   = (LOG2 > 0) ? LOG2 : 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_WAIT_RD = 3'd2;
    localparam logic [2:0] S_LATCH   = 3'd3;
    localparam logic [2:0] S_PLOT    = 3'd4;
    localparam logic [2:0] S_NEXT    = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    logic [2:0]    r_state;
    logic [5:0]    r_cx;
    logic [4:0]    r_cy;
    logic [5:0]    r_gx;
    logic [4:0]    r_gy;
    logic [DW-1:0] r_dx;
    logic [DW-1:0] r_dy;
    logic [2:0]    r_colour;
    logic          r_done;

    logic [2:0]    w_colour;
    logic          w_dx_last;
    logic          w_dy_last;
    logic          w_cell_last;

    always_comb begin
        w_colour = '0;
        case (grid_out)
            3'd0:    w_colour = 3'b000;
            3'd1:    w_colour = 3'b111;
            3'd2:    w_colour = 3'b010;
            3'd3:    w_colour = 3'b001;
            3'd4:    w_colour = 3'b100;
            default: w_colour = 3'b110;
        endcase
    end

    assign w_dx_last   = (r_dx == DW'(CELL_PX - 1));
    assign w_dy_last   = (r_dy == DW'(CELL_PX - 1));
    assign w_cell_last = (r_cx == 6'(GRID_W - 1)) && (r_cy == 5'(GRID_H - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_cx     <= '0;
            r_cy     <= '0;
            r_gx     <= '0;
            r_gy     <= '0;
            r_dx     <= '0;
            r_dy     <= '0;
            r_colour <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cx    <= '0;
                        r_cy    <= '0;
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_gx    <= r_cx;
                    r_gy    <= r_cy;
                    r_state <= S_WAIT_RD;
                end
                S_WAIT_RD: r_state <= S_LATCH;
                S_LATCH: begin
                    r_colour <= w_colour;
                    r_state  <= S_PLOT;
                end
                S_PLOT: begin
                    if (w_dx_last) begin
                        r_dx <= '0;
                        if (w_dy_last) begin
                            r_dy    <= '0;
                            r_state <= S_NEXT;
                        end else begin
                            r_dy <= r_dy + DW'(1);
                        end
                    end else begin
                        r_dx <= r_dx + DW'(1);
                    end
                end
                S_NEXT: begin
                    // r_done is raised here so it is high exactly while in DONE
                    if (w_cell_last) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        if (r_cx == 6'(GRID_W - 1)) begin
                            r_cx <= '0;
                            r_cy <= r_cy + 5'd1;
                        end else begin
                            r_cx <= r_cx + 6'd1;
                        end
                        r_state <= S_FETCH;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign done   = r_done;
    assign busy   = (r_state != S_IDLE);
    assign plot   = (r_state == S_PLOT);
    assign grid_x = r_gx;
    assign grid_y = r_gy;
    assign colour = r_colour;
    assign vga_x  = (8'(r_gx) << LOG2) | 8'(r_dx);
    assign vga_y  = (7'(r_gy) << LOG2) | 7'(r_dy);

endmodule

// File: tb/tb_grid_renderer.sv
// Directed bench for grid_renderer: RAM model with 1-cycle read latency,
// pixel framebuffer scoreboard, table of expected pixels plus corner sequences.
module tb_grid_renderer;

    logic       clock;
    logic       rst_n;
    logic       start;
    logic       done;
    logic       busy;
    logic [5:0] grid_x;
    logic [4:0] grid_y;
    logic [2:0] grid_out;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] colour;
    logic       plot;

    grid_renderer #(.GRID_W(40), .GRID_H(30), .CELL_PX(4)) dut (
        .clock(clock), .reset(rst_n), .start(start), .done(done), .busy(busy),
        .grid_x(grid_x), .grid_y(grid_y), .grid_out(grid_out),
        .vga_x(vga_x), .vga_y(vga_y), .colour(colour), .plot(plot)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [2:0] gmem [0:39][0:29];
    logic [2:0] fb   [0:159][0:119];

    always @(posedge clock) begin
        if (grid_x < 6'd40 && grid_y < 5'd30) grid_out <= gmem[grid_x][grid_y];
        else grid_out <= 3'd0;
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;
    int start_cyc;
    int plot_cnt, nz_cnt, red_cnt, white_cnt, order_err, done_cnt;
    int last_x, last_y, last_c;

    // White plots of cell (5,2) must arrive dx-first, then dy
    always @(negedge clock) begin
        if (plot) begin
            plot_cnt++;
            if (colour != 3'd0) nz_cnt++;
            if (colour == 3'b100) red_cnt++;
            if (colour == 3'b111) begin
                if (int'(vga_x) != 20 + (white_cnt % 4) || int'(vga_y) != 8 + (white_cnt / 4))
                    order_err++;
                white_cnt++;
            end
            last_x = vga_x;
            last_y = vga_y;
            last_c = colour;
            if (vga_x < 8'd160 && vga_y < 7'd120) fb[vga_x][vga_y] = colour;
        end
        if (done) done_cnt++;
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_counts();
        plot_cnt = 0; nz_cnt = 0; red_cnt = 0; white_cnt = 0;
        order_err = 0; done_cnt = 0; last_x = -1; last_y = -1; last_c = -1;
    endtask

    // Called just after a negedge; start is sampled by the next posedge (edge 0)
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        start_cyc = cyc;
        clear_counts();
    endtask

    task automatic wait_done(input int budget, input bit spam, output int lat);
        int k;
        bit found;
        k = 0;
        found = 1'b0;
        while (!found && k < budget) begin
            @(negedge clock);
            k++;
            if (done) found = 1'b1;
            start = spam && !found && (k % 4000 == 7);
        end
        start = 1'b0;
        if (!found) check("done_timeout", 0, 1);
        lat = cyc - start_cyc;
    endtask

    typedef struct {
        int x;
        int y;
        int c;
    } pix_vec_t;

    pix_vec_t vecs [19];

    initial begin
        int lat, pc, k;
        bit found;

        vecs[0]  = '{156, 116, 4};
        vecs[1]  = '{159, 119, 4};
        vecs[2]  = '{158, 117, 4};
        vecs[3]  = '{155, 119, 0};
        vecs[4]  = '{159, 115, 0};
        vecs[5]  = '{20, 8, 7};
        vecs[6]  = '{23, 11, 7};
        vecs[7]  = '{21, 10, 7};
        vecs[8]  = '{19, 9, 0};
        vecs[9]  = '{24, 10, 0};
        vecs[10] = '{20, 12, 0};
        vecs[11] = '{0, 0, 2};
        vecs[12] = '{3, 3, 2};
        vecs[13] = '{5, 1, 1};
        vecs[14] = '{8, 0, 6};
        vecs[15] = '{13, 2, 6};
        vecs[16] = '{19, 3, 6};
        vecs[17] = '{20, 0, 0};
        vecs[18] = '{100, 60, 0};

        for (int x = 0; x < 40; x++)
            for (int y = 0; y < 30; y++)
                gmem[x][y] = 3'd0;
        clear_counts();

        rst_n = 1'b0;
        start = 1'b0;
        repeat (6) begin
            @(negedge clock);
            start = ~start;
        end
        check("rst_plot", int'(plot), 0);
        check("rst_done", int'(done), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_grid_x", int'(grid_x), 0);
        check("rst_grid_y", int'(grid_y), 0);
        check("rst_colour", int'(colour), 0);
        start = 1'b0;
        @(negedge clock);
        rst_n = 1'b1;
        repeat (10) @(negedge clock);
        check("idle_busy", int'(busy), 0);
        check("idle_plots", plot_cnt, 0);

        // Render 1: all air, start spammed mid-render
        pulse_start();
        wait_done(30000, 1'b1, lat);
        #1;
        check("r1_done_cycle", lat, 24000);
        check("r1_plots", plot_cnt, 19200);
        check("r1_nonblack", nz_cnt, 0);
        check("r1_done_count", done_cnt, 1);
        @(posedge clock);
        #1;
        check("r1_busy_after", int'(busy), 0);
        check("r1_done_after", int'(done), 0);

        gmem[39][29] = 3'd4;
        gmem[5][2]   = 3'd1;
        gmem[0][0]   = 3'd2;
        gmem[1][0]   = 3'd3;
        gmem[2][0]   = 3'd5;
        gmem[3][0]   = 3'd6;
        gmem[4][0]   = 3'd7;
        for (int x = 0; x < 160; x++)
            for (int y = 0; y < 120; y++)
                fb[x][y] = 3'b101;

        // Render 2 starts in the cycle right after done
        pulse_start();
        check("r2_busy_start", int'(busy), 1);
        wait_done(30000, 1'b0, lat);
        #1;
        check("r2_done_cycle", lat, 24000);
        check("r2_plots", plot_cnt, 19200);
        check("r2_red", red_cnt, 16);
        check("r2_white", white_cnt, 16);
        check("r2_white_order", order_err, 0);
        check("r2_last_x", last_x, 159);
        check("r2_last_y", last_y, 119);
        check("r2_last_c", last_c, 4);
        check("r2_done_count", done_cnt, 1);
        for (int i = 0; i < 19; i++)
            check($sformatf("pix(%0d,%0d)", vecs[i].x, vecs[i].y),
                  int'(fb[vecs[i].x][vecs[i].y]), vecs[i].c);

        // Render 3: asynchronous reset mid-PLOT of cell (10,10)
        @(posedge clock);
        #1;
        pulse_start();
        found = 1'b0;
        k = 0;
        while (!found && k < 20000) begin
            @(negedge clock);
            k++;
            if (plot && vga_x == 8'd41 && vga_y == 7'd41) found = 1'b1;
        end
        check("abort_reached", int'(found), 1);
        check("abort_grid_x", int'(grid_x), 10);
        check("abort_grid_y", int'(grid_y), 10);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_plot", int'(plot), 0);
        check("abort_busy", int'(busy), 0);
        pc = plot_cnt;
        repeat (5) @(negedge clock);
        rst_n = 1'b1;
        repeat (10) @(negedge clock);
        check("abort_no_done", done_cnt, 0);
        check("abort_no_plots", plot_cnt, pc);

        // Render 4: restarts from cell (0,0)
        pulse_start();
        found = 1'b0;
        k = 0;
        while (!found && k < 100) begin
            @(negedge clock);
            k++;
            if (plot) found = 1'b1;
        end
        check("r4_plot_seen", int'(found), 1);
        check("r4_first_plot_cycle", cyc - start_cyc, 3);
        check("r4_vga_x", int'(vga_x), 0);
        check("r4_vga_y", int'(vga_y), 0);
        check("r4_grid_x", int'(grid_x), 0);
        check("r4_grid_y", int'(grid_y), 0);
        check("r4_colour", int'(colour), 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
